// File: rtl/encoder42_reg.sv
// Registered 4-to-2 priority event encoder: captures rising edges on d3..d0,
// queues them as pending bits and presents them one at a time under ack handshake.
module encoder42_reg (
    input  logic clk,
    input  logic rst,
    input  logic e,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic ack,
    output logic a,
    output logic b,
    output logic v,
    output logic ovf
);

    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned CODE_W    = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_LINES-1:0]   r_prev;
    logic [NUM_LINES-1:0]   r_pending;
    logic [NUM_LINES-1:0]   w_d;
    logic [NUM_LINES-1:0]   w_event;
    logic [NUM_LINES-1:0]   w_sel;
    logic [NUM_LINES-1:0]   w_clr;
    logic [CODE_W-1:0]      w_code;
    logic                   w_any;
    logic                   w_load;

    assign w_d     = {d3, d2, d1, d0};
    assign w_event = e ? (w_d & ~r_prev) : '0;
    assign w_any   = |r_pending;

    // Highest set pending bit, as a one-hot select and its binary index
    always_comb begin
        w_sel  = '0;
        w_code = '0;
        if (r_pending[3]) begin
            w_sel  = 4'b1000;
            w_code = 2'd3;
        end else if (r_pending[2]) begin
            w_sel  = 4'b0100;
            w_code = 2'd2;
        end else if (r_pending[1]) begin
            w_sel  = 4'b0010;
            w_code = 2'd1;
        end else if (r_pending[0]) begin
            w_sel  = 4'b0001;
            w_code = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)         w_state_nxt = ST_HOLD;
            ST_HOLD: if (ack && !w_any) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // A new code is taken whenever the presented slot is free or being released
    always_comb begin
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: w_load = w_any;
            ST_HOLD: w_load = ack && w_any;
            default: w_load = 1'b0;
        endcase
        w_clr = w_load ? w_sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            v         <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            r_prev    <= w_d;
            // Set after clear, so a re-trigger on the consuming edge survives
            r_pending <= (r_pending & ~w_clr) | w_event;
            ovf       <= ovf | (|(w_event & r_pending & ~w_clr));
            v         <= (w_state_nxt == ST_HOLD);
            if (w_load) begin
                {a, b} <= w_code;
            end else if (w_state_nxt == ST_IDLE) begin
                {a, b} <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_encoder42_reg.sv
// Self-checking bench for encoder42_reg: per-cycle vector table with a scoreboard
// queue of expected {a,b,v,ovf}, plus hand sequences for reset behaviour.
module tb_encoder42_reg;

    logic clk;
    logic rst;
    logic e;
    logic d0, d1, d2, d3;
    logic ack;
    logic a, b, v, ovf;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic       rst;
        logic       e;
        logic [3:0] d;
        logic       ack;
        logic [3:0] exp;   // {a,b,v,ovf} after the edge
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];

    encoder42_reg dut (
        .clk (clk),
        .rst (rst),
        .e   (e),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .ack (ack),
        .a   (a),
        .b   (b),
        .v   (v),
        .ovf (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic en, input logic [3:0] d,
                       input logic ak, input logic [3:0] exp);
        vec_t t;
        t.rst = r; t.e = en; t.d = d; t.ack = ak; t.exp = exp;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got {a,b,v,ovf}=%b required %b", name, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [3:0] d, input logic ak);
        rst = r; e = en; {d3, d2, d1, d0} = d; ack = ak;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b0, 4'b0000, 1'b0);

        // Single event on d2, then ack
        add(0,1,4'b0100,0, 4'b0000);
        add(0,1,4'b0000,0, 4'b1010);
        add(0,1,4'b0000,1, 4'b0000);
        // d3,d1,d0 together with ack held: 11,01,00 back to back
        add(0,1,4'b1011,1, 4'b0000);
        add(0,1,4'b1011,1, 4'b1110);
        add(0,1,4'b1011,1, 4'b0110);
        add(0,1,4'b1011,1, 4'b0010);
        add(0,1,4'b1011,1, 4'b0000);
        add(0,1,4'b0000,0, 4'b0000);
        // Enable gating on d1, then a fresh rise with e=1
        add(0,0,4'b0010,0, 4'b0000);
        add(0,0,4'b0010,0, 4'b0000);
        add(0,1,4'b0010,0, 4'b0000);
        add(0,1,4'b0000,0, 4'b0000);
        add(0,1,4'b0010,0, 4'b0000);
        add(0,1,4'b0010,0, 4'b0110);
        add(0,1,4'b0000,1, 4'b0000);
        // Overflow: d0 rises twice while 11 is held
        add(0,1,4'b1000,0, 4'b0000);
        add(0,1,4'b0000,0, 4'b1110);
        add(0,1,4'b0001,0, 4'b1110);
        add(0,1,4'b0000,0, 4'b1110);
        add(0,1,4'b0001,0, 4'b1111);
        add(0,1,4'b0000,1, 4'b0011);
        add(0,1,4'b0000,1, 4'b0001);
        add(0,1,4'b0000,0, 4'b0001);
        // Reset clears ovf; d1 already high at the first edge after release counts
        add(1,1,4'b0010,0, 4'b0000);
        add(0,1,4'b0010,0, 4'b0000);
        add(0,1,4'b0000,0, 4'b0110);
        // d3 re-rises on the edge that loads 11
        add(0,1,4'b1000,0, 4'b0110);
        add(0,1,4'b0000,0, 4'b0110);
        add(0,1,4'b1000,1, 4'b1110);
        add(0,1,4'b1000,1, 4'b1110);
        add(0,1,4'b0000,1, 4'b0000);
        // Build up v=1 with two more pending for the reset sequence below
        add(0,1,4'b0111,0, 4'b0000);
        add(0,1,4'b0111,0, 4'b1010);

        @(negedge clk);
        @(negedge clk);
        check("reset_state", {a, b, v, ovf}, 4'b0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].e, vecs[i].d, vecs[i].ack);
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {a, b, v, ovf}, sb.pop_front());
        end

        // Asynchronous reset while v=1 with pending 0011
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst", {a, b, v, ovf}, 4'b0000);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d", k), {a, b, v, ovf}, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/encoder42_reg.md
ENCODER42_REG -- requirements
Module: encoder42_reg

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: e  input  1  enable; 1 = new input events are captured.
REQ-004 SHALL have: d0, d1, d2, d3  input  1 each  event request lines; d3 is highest priority, d0 is lowest.
REQ-005 SHALL have: ack  input  1  consumer acknowledge of the presented code.
REQ-006 SHALL have: a  output  1  code MSB, registered.
REQ-007 SHALL have: b  output  1  code LSB, registered; {a,b} = binary index of the presented line (d2 -> a=1, b=0).
REQ-008 SHALL have: v  output  1  registered; 1 = {a,b} holds a valid code.
REQ-009 SHALL have: ovf  output  1  sticky overflow flag, registered.

Function
REQ-010 SHALL keep prev[3:0] registers that sample d3..d0 every clock, regardless of e.
REQ-011 SHALL detect an event on line i when e=1, d_i=1 and prev[i]=0 at a rising edge; on that edge pending[i] SHALL be set to 1.
REQ-012 SHALL NOT create an event when e=0; pending bits already set SHALL remain set and continue to drain.
REQ-013 SHALL use a two-state FSM: IDLE (v=0) and HOLD (v=1).
REQ-014 In IDLE with pending!=0, on the next edge the block SHALL load {a,b} with the index of the highest set pending bit, clear that bit, set v=1 and enter HOLD.
REQ-015 In IDLE with pending==0, the block SHALL stay in IDLE with v=0 and {a,b}=00.
REQ-016 In HOLD with ack=0, {a,b} and v SHALL remain stable.
REQ-017 In HOLD with ack=1 and pending!=0 (evaluated before this edge's set), the block SHALL load the next highest code on that edge, stay in HOLD, and keep v=1, giving back-to-back codes with no gap.
REQ-018 In HOLD with ack=1 and pending==0, the block SHALL enter IDLE on that edge with v=0 and {a,b}=00.
REQ-019 SHALL ignore ack while in IDLE.
REQ-020 Latency: an event sampled at edge t with FSM in IDLE and no higher pending SHALL give v=1 with its code after edge t+1, i.e. 2 clocks from input edge to valid output.
REQ-021 When the same edge both sets and clears pending[i], the set SHALL win and the bit SHALL remain 1.
REQ-022 When a new event on line i arrives while pending[i]=1 and pending[i] is not cleared on that edge, ovf SHALL become 1; the event SHALL be merged.
REQ-023 ovf SHALL stay 1 until rst.
REQ-024 When several events arrive on the same edge, all SHALL be captured and presented in strict priority order d3, d2, d1, d0; lower lines SHALL be starved while higher lines keep re-triggering (accepted behaviour).
REQ-025 A line held high SHALL produce exactly one event per 0->1 transition.

Reset
REQ-026 While rst=1, asynchronously: v=0, a=0, b=0, ovf=0, pending=0000, prev=0000, FSM=IDLE.
REQ-027 Reset asserted mid-operation SHALL discard all pending events and any presented code; no ack is required afterwards.
REQ-028 Because prev resets to 0, a line that is already high at the first edge after rst deasserts with e=1 SHALL count as one event.

Verification
REQ-029 The bench SHALL cover single event: e=1, d2 pulsed 0->1 at edge 1 -> v=1, a=1, b=0 after edge 2; ack at edge 3 -> v=0, {a,b}=00 after edge 3.
REQ-030 The bench SHALL cover simultaneous events: d0, d1, d3 rise on the same edge, ack held 1 -> codes 11, 01, 00 on consecutive cycles with v continuously 1, then v=0.
REQ-031 The bench SHALL cover enable gating: e=0 while d1 rises -> v stays 0 and pending stays 0; with e=1 and d1 falling then rising again -> code 01 presented.
REQ-032 The bench SHALL cover overflow: d0 rises twice while code 11 is held un-acked -> ovf=1 and stays 1; d0 is presented once; ovf clears only on rst.
REQ-033 The bench SHALL cover a same-edge set and clear: d3 re-rises on the edge that loads code 11 -> pending[3] stays 1, ovf=0, and 11 is presented again after ack.
REQ-034 The bench SHALL cover reset mid-operation: rst pulsed while v=1 with two pending events -> outputs all 0 immediately; after release with all d lines low, v stays 0.
